// File: rtl/alu_pkg.sv
// alu_pkg: command codes, datapath widths and divider FSM states shared by the ALU breadboard blocks
package alu_pkg;
    localparam logic [3:0] ALU_CMD_DIV = 4'd4;
    localparam logic [3:0] ALU_CMD_MOD = 4'd5;
    localparam int DATA_W = 16;
    localparam int RESULT_W = 32;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done launch handshake plus operand and result words of the divider
interface seq_divider_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OUT_WIDTH = RESULT_W
);
    logic                 start;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] quotient;
    logic [OUT_WIDTH-1:0] remainder;
    logic                 error;
    modport master (output start, dividend, divisor, input busy, done, quotient, remainder, error);
    modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, error);
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration, shifting {rem,quo} left and trial-subtracting the divisor
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);
    logic [WIDTH:0] sh;
    logic           borrow;
    // rem < divisor on entry, so a successful subtraction always fits back into WIDTH bits
    always_comb begin
        sh = {rem, quo[WIDTH-1]};
        borrow = sh < {1'b0, divisor};
        next_rem = borrow ? sh[WIDTH-1:0] : WIDTH'(sh - {1'b0, divisor});
        next_quo = {quo[WIDTH-2:0], ~borrow};
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for the DIV/MOD channels, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands with sign-extended results.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OUT_WIDTH = RESULT_W
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] x);
        return {{(OUT_WIDTH-WIDTH){SGN & x[WIDTH-1]}}, x};
    endfunction

    div_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic                 a_neg_q, a_neg_d, b_neg_q, b_neg_d, ovf_q, ovf_d;
    logic [OUT_WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     nq, nr;
    logic                 a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dsr_q),
        .next_rem (nr),
        .next_quo (nq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            err_q   <= err_d;
        end
    end

    // Results are registered on the edge entering DONE so they stay stable until the next completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        err_d   = err_q;
        a_neg   = SGN & bus.dividend[WIDTH-1];
        b_neg   = SGN & bus.divisor[WIDTH-1];
        unique case (state_q)
            DIV_IDLE: if (bus.start) begin
                a_neg_d = a_neg;
                b_neg_d = b_neg;
                ovf_d   = SGN && bus.dividend == MIN_NEG && bus.divisor == '1;
                quo_d   = a_neg ? -bus.dividend : bus.dividend;
                dsr_d   = b_neg ? -bus.divisor : bus.divisor;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = bus.divisor == '0 ? DIV_DONE : DIV_RUN;
                if (bus.divisor == '0) begin
                    quot_d = {{(OUT_WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}};
                    rmd_d  = ext(bus.dividend);
                    err_d  = 1'b1;
                end
            end
            DIV_RUN: begin
                rem_d = nr;
                quo_d = nq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DIV_DONE;
                    quot_d  = ext((a_neg_q ^ b_neg_q) ? -nq : nq);
                    rmd_d   = ext(a_neg_q ? -nr : nr);
                    err_d   = ovf_q;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    assign bus.busy      = state_q != DIV_IDLE;
    assign bus.done      = state_q == DIV_DONE;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rmd_q;
    assign bus.error     = err_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven vectors with a done-time scoreboard, plus handshake, ignore and reset sequences
module tb_seq_divider;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[$];

    seq_divider_if bus ();

    seq_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding launch
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("error", 32'(bus.error), 32'(e.e));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] q,
                            input logic [31:0] r, input logic e, input int lat);
        exp_t x;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        x.q = q;
        x.r = r;
        x.e = e;
        x.cyc = cyc + 1 + lat;
        sb.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 16'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || bus.busy) && n < 60);
        checks++;
        if (sb.size() != 0 || bus.busy) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending results busy=%0b expected 0 pending busy=0", name, sb.size(), bus.busy);
            sb.delete();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor = 16'd0;

        vecs.push_back('{16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16});
        vecs.push_back('{16'd5, 16'd0, 32'h0000FFFF, 32'd5, 1'b1, 0});
        vecs.push_back('{16'd9, 16'd3, 32'd3, 32'd0, 1'b0, 16});
        vecs.push_back('{16'd1000, 16'd33, 32'd30, 32'd10, 1'b0, 16});
        vecs.push_back('{16'd0, 16'd5, 32'd0, 32'd0, 1'b0, 16});
        vecs.push_back('{16'd12345, 16'd12345, 32'd1, 32'd0, 1'b0, 16});
        vecs.push_back('{16'd7, 16'd8, 32'd0, 32'd7, 1'b0, 16});
        vecs.push_back('{16'd0, 16'd0, 32'h0000FFFF, 32'd0, 1'b1, 0});
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back('{16'hFFF9, 16'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 16});
        vecs.push_back('{16'd7, 16'hFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 16});
        vecs.push_back('{16'h8000, 16'hFFFF, 32'hFFFF8000, 32'd0, 1'b1, 16});
        vecs.push_back('{16'hFF9C, 16'hFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 16});
        vecs.push_back('{16'd3, 16'hFFFF, 32'hFFFFFFFD, 32'd0, 1'b0, 16});
`else
        vecs.push_back('{16'd65535, 16'd1, 32'd65535, 32'd0, 1'b0, 16});
        vecs.push_back('{16'd3, 16'd65535, 32'd0, 32'd3, 1'b0, 16});
        vecs.push_back('{16'd65535, 16'd256, 32'd255, 32'd255, 1'b0, 16});
        vecs.push_back('{16'd40000, 16'd7, 32'd5714, 32'd2, 1'b0, 16});
`endif

        // Reset with a start request held high: reset must win
        bus.start = 1'b1;
        bus.divisor = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lat);
            wait_idle("vector");
        end

        // busy window for a normal division: cycles 1..17 high, low at 18
        start_op(16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16);
        check("busy_c1", 32'(bus.busy), 32'd1);
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            check("busy_run", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check("busy_c18", 32'(bus.busy), 32'd0);
        wait_idle("busy_window");

        // start during RUN is ignored and results hold during RUN
        start_op(16'd9, 16'd3, 32'd3, 32'd0, 1'b0, 16);
        wait_idle("pre_ignore");
        start_op(16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16);
        repeat (4) @(negedge clk);
        check("hold_quotient", bus.quotient, 32'd3);
        check("hold_remainder", bus.remainder, 32'd0);
        bus.start = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("ignore_run");

        // start during the DONE cycle is ignored too
        start_op(16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16);
        repeat (16) @(negedge clk);
        check("done_c17", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("ignore_done_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end

        // reset mid-operation aborts with no done
        start_op(16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 16);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_error", 32'(bus.error), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        start_op(16'd9, 16'd3, 32'd3, 32'd0, 1'b0, 16);
        wait_idle("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
